quat_op_scheduler: RTL and testbench
====================================

Name: quat_op_scheduler

Overview:
Sequences the quaternion multiply datapath behind the spi_slave front-end. Collects two consecutive received quaternions (operand A, then operand B) from the spi_slave q0..q3/data_ready interface and issues a one-cycle start to the quaternion multiplier. Waits for the multiplier's done with a timeout, then holds the product under a valid/ready handshake for the return path. Runs in the same sclk domain as spi_slave; no CDC inside.

Parameters:
W, 16, component width (matches spi_slave q0..q3)
TIMEOUT, 64, max WAIT cycles allowed for mul_done (>=1)

Ports:
sclk  in  1  clock, same clock as spi_slave
rst  in  1  reset, asynchronous, active-high
data_ready  in  1  one-cycle pulse from spi_slave, q0..q3 valid that cycle
q0  in  W  quaternion component 0 (scalar)
q1  in  W  component 1
q2  in  W  component 2
q3  in  W  component 3
op_a  out  4W  operand A, packed {q3,q2,q1,q0}, q0 in bits [W-1:0]
op_b  out  4W  operand B, same packing
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  one-cycle pulse, mul_res valid that cycle
mul_res  in  4W  product, same packing
res  out  4W  latched product
res_valid  out  1  res valid, held until accepted
res_ready  in  1  downstream accept
op_count  out  16  completed products, wraps 0xFFFF->0
overrun  out  1  sticky: data_ready dropped
timeout_err  out  1  sticky: multiplier timeout
clr_err  in  1  clears overrun and timeout_err

Behaviour:
- Reset (async, immediate): state IDLE; op_a, op_b, res, op_count, timer = 0; mul_start, res_valid, overrun, timeout_err = 0. Reset mid-operation aborts, no pulse completes.
- States: IDLE, GOT_A, ISSUE, WAIT, HOLD.
- IDLE: data_ready -> op_a <= {q3,q2,q1,q0}, go GOT_A.
- GOT_A: data_ready -> op_b <= {q3,q2,q1,q0}, go ISSUE.
- ISSUE: mul_start = 1 for exactly this one cycle (registered output), timer <= 0, go WAIT.
- WAIT: timer increments each cycle, first WAIT cycle counts as 1.
  - mul_done = 1 -> res <= mul_res, res_valid <= 1, op_count <= op_count+1, go HOLD.
  - mul_done = 0 and timer == TIMEOUT -> timeout_err <= 1, go IDLE, no result, op_count unchanged.
  - mul_done on the TIMEOUT-th WAIT cycle is accepted; done wins over timeout.
- HOLD: res and res_valid stable. res_valid && res_ready -> res_valid <= 0 next cycle, go IDLE.
- data_ready in ISSUE, WAIT or HOLD: packet dropped, overrun <= 1, op_a/op_b unchanged.
- mul_done outside WAIT: ignored, no state or flag change.
- op_a/op_b change only on their capture cycle; stable through ISSUE/WAIT/HOLD.
- res changes only on accepted mul_done.
- clr_err clears both sticky flags next cycle. Same-cycle set condition wins (flag stays 1).
- Timer width clog2(TIMEOUT+1). op_count arithmetic is modulo 2^16.
- Back-to-back: after HOLD handshake, data_ready on the first IDLE cycle is captured as new op_a.

Test Plan:
- Reset then data_ready with q=(1,2,3,4), then q=(5,6,7,8) -> op_a=0x0004_0003_0002_0001, op_b=0x0008_0007_0006_0005, one mul_start pulse exactly one cycle after second capture.
- mul_done on 3rd WAIT cycle with mul_res=0x1111_2222_3333_4444, res_ready=0 for 5 cycles then 1 -> res_valid held 6 cycles, res stable, op_count=1, back to IDLE.
- No mul_done, TIMEOUT=4 -> timeout_err=1 after 4th WAIT cycle, res_valid stays 0, op_count=0; mul_done on 4th WAIT cycle instead -> accepted, no error.
- data_ready during WAIT and during HOLD -> overrun=1, op_a/op_b unchanged; clr_err -> overrun=0; clr_err coincident with new drop -> overrun stays 1.
- Assert rst mid-WAIT and mid-HOLD -> all outputs 0 immediately, next pair of data_ready pulses completes a normal transaction.
- Preload op_count to 0xFFFF via 65535 transactions (or forced) then one more -> op_count=0x0000.

Source files
------------

// File: rtl/quat_op_scheduler.sv
// quat_op_scheduler: pairs two received quaternions into a multiply request and
// holds the product under a valid/ready handshake, with overrun and timeout flags.
module quat_op_scheduler #(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic           sclk,
    input  logic           rst,
    input  logic           data_ready,
    input  logic [W-1:0]   q0,
    input  logic [W-1:0]   q1,
    input  logic [W-1:0]   q2,
    input  logic [W-1:0]   q3,
    output logic [4*W-1:0] op_a,
    output logic [4*W-1:0] op_b,
    output logic           mul_start,
    input  logic           mul_done,
    input  logic [4*W-1:0] mul_res,
    output logic [4*W-1:0] res,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [15:0]    op_count,
    output logic           overrun,
    output logic           timeout_err,
    input  logic           clr_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, GOT_A, ISSUE, WAIT, HOLD} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_inc;
    logic          drop, done_ok, tmo;

    // timer_inc is the 1-based index of the current WAIT cycle
    assign timer_inc = timer + TW'(1);
    assign drop      = data_ready && (state == ISSUE || state == WAIT || state == HOLD);
    assign done_ok   = state == WAIT && mul_done;
    assign tmo       = state == WAIT && !mul_done && timer_inc == TW'(TIMEOUT);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = data_ready ? GOT_A : IDLE;
            GOT_A:   state_n = data_ready ? ISSUE : GOT_A;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = mul_done ? HOLD : (tmo ? IDLE : WAIT);
            HOLD:    state_n = res_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            res         <= '0;
            op_count    <= '0;
            timer       <= '0;
            mul_start   <= 1'b0;
            res_valid   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            mul_start   <= state_n == ISSUE;
            timer       <= state == WAIT ? timer_inc : '0;
            res_valid   <= done_ok | (res_valid & ~res_ready);
            overrun     <= drop | (overrun & ~clr_err);
            timeout_err <= tmo | (timeout_err & ~clr_err);
            if (state == IDLE && data_ready)
                op_a <= {q3, q2, q1, q0};
            if (state == GOT_A && data_ready)
                op_b <= {q3, q2, q1, q0};
            if (done_ok) begin
                res      <= mul_res;
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_quat_op_scheduler.sv
// tb_quat_op_scheduler: randomized transactions against a quaternion-product
// reference; a negedge monitor scores every accepted result from a queue.
module tb_quat_op_scheduler;
    localparam int W  = 16;
    localparam int TO = 4;

    logic           sclk = 0, rst = 1, data_ready = 0, mul_done = 0, res_ready = 0, clr_err = 0;
    logic [W-1:0]   q0, q1, q2, q3;
    logic [4*W-1:0] op_a, op_b, res, mul_res = '0;
    logic           mul_start, res_valid, overrun, timeout_err;
    logic [15:0]    op_count;

    int          n_tests = 0, n_fail = 0;
    logic [79:0] sb[$];
    logic [79:0] sb_e;
    logic [15:0] exp_cnt = 0;
    bit          exp_ovr = 0, exp_to = 0, drop_now = 0, tmo_now = 0;
    logic [63:0] prev_res = '0;
    bit          prev_v = 0;

    quat_op_scheduler #(.W(W), .TIMEOUT(TO)) dut (
        .sclk(sclk), .rst(rst), .data_ready(data_ready),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .op_a(op_a), .op_b(op_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_res(mul_res),
        .res(res), .res_valid(res_valid), .res_ready(res_ready),
        .op_count(op_count), .overrun(overrun), .timeout_err(timeout_err),
        .clr_err(clr_err)
    );

    always #5 sclk = ~sclk;

    function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Hamilton product, component 0 is the scalar, arithmetic modulo 2^16
    function automatic logic [63:0] qmul(input logic [63:0] a, input logic [63:0] b);
        logic [15:0] x[4], y[4], r[4];
        for (int i = 0; i < 4; i++) begin
            x[i] = a[16*i +: 16];
            y[i] = b[16*i +: 16];
        end
        r[0] = x[0]*y[0] - x[1]*y[1] - x[2]*y[2] - x[3]*y[3];
        r[1] = x[0]*y[1] + x[1]*y[0] + x[2]*y[3] - x[3]*y[2];
        r[2] = x[0]*y[2] - x[1]*y[3] + x[2]*y[0] + x[3]*y[1];
        r[3] = x[0]*y[3] + x[1]*y[2] - x[2]*y[1] + x[3]*y[0];
        return {r[3], r[2], r[1], r[0]};
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic set_q(input logic [63:0] v);
        {q3, q2, q1, q0} = v;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // advance one clock and check the sticky flags against their rule-level model
    task automatic tick();
        bit no, nt;
        no = drop_now | (exp_ovr & !clr_err);
        nt = tmo_now | (exp_to & !clr_err);
        @(posedge sclk);
        #1;
        exp_ovr  = no;
        exp_to   = nt;
        drop_now = 0;
        tmo_now  = 0;
        chk("overrun", overrun, exp_ovr);
        chk("timeout_err", timeout_err, exp_to);
    endtask

    task automatic clr();
        clr_err = 1;
        tick();
        clr_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op_a"}, op_a, 0);
        chk({tag, "_op_b"}, op_b, 0);
        chk({tag, "_res"}, res, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_mul_start"}, mul_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #1;
        chk_zero("async_rst");
        data_ready = 0; mul_done = 0; res_ready = 0; clr_err = 0;
        drop_now = 0; tmo_now = 0; exp_ovr = 0; exp_to = 0; exp_cnt = 0;
        sb.delete();
        @(posedge sclk);
        #2 rst = 0;
    endtask

    // one request: lat = WAIT cycle of mul_done (>TO means never), hold = ready-low cycles
    task automatic txn(input logic [63:0] a, input logic [63:0] b, input int lat, input int hold,
                       input bit dw, input bit dwc, input bit dh, input bit rw, input bit rh);
        data_ready = 1; set_q(a); tick(); data_ready = 0;
        repeat ($urandom_range(0, 2)) tick();
        data_ready = 1; set_q(b); tick(); data_ready = 0;
        chk("mul_start_issue", mul_start, 1);
        chk("op_a_capture", op_a, a);
        chk("op_b_capture", op_b, b);
        tick();
        chk("mul_start_wait", mul_start, 0);
        for (int k = 1; k <= TO; k++) begin
            if (rw && k == 2) begin
                do_reset();
                return;
            end
            if (k == lat) begin
                mul_done = 1;
                mul_res  = qmul(op_a, op_b);
                exp_cnt++;
                sb.push_back({qmul(a, b), exp_cnt});
            end
            if (dw && k == 1) begin
                data_ready = 1; set_q(rnd64()); drop_now = 1; clr_err = dwc;
            end
            tmo_now = lat > TO && k == TO;
            tick();
            mul_done = 0; data_ready = 0; clr_err = 0;
            if (k == lat) break;
        end
        chk("op_a_stable", op_a, a);
        chk("op_b_stable", op_b, b);
        if (lat > TO) begin
            chk("res_valid_timeout", res_valid, 0);
            chk("op_count_timeout", op_count, exp_cnt);
            return;
        end
        chk("res_valid_set", res_valid, 1);
        for (int h = 0; h < hold; h++) begin
            if (rh && h == 1) begin
                do_reset();
                return;
            end
            if (dh && h == 0) begin
                data_ready = 1; set_q(rnd64()); drop_now = 1;
            end
            tick();
            data_ready = 0;
            chk("res_valid_hold", res_valid, 1);
        end
        chk("op_a_hold", op_a, a);
        chk("op_b_hold", op_b, b);
        res_ready = 1; tick(); res_ready = 0;
        chk("res_valid_clr", res_valid, 0);
    endtask

    always @(negedge sclk) begin
        if (res_valid && prev_v)
            chk("res_stable", res, prev_res);
        prev_v   = res_valid;
        prev_res = res;
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got result %h, expected none queued", res);
            end else begin
                sb_e = sb.pop_front();
                chk("res", res, sb_e[79:16]);
                chk("op_count", op_count, sb_e[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        set_q('0);
        repeat (2) @(posedge sclk);
        #1;
        chk_zero("reset");
        rst = 0;
        tick();
        txn(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 3, 5, 0, 0, 0, 0, 0);
        chk("count_first", op_count, 1);
        txn(rnd64(), rnd64(), TO + 1, 0, 0, 0, 0, 0, 0);
        txn(rnd64(), rnd64(), TO, 1, 0, 0, 0, 0, 0);
        clr();
        txn(rnd64(), rnd64(), 2, 2, 1, 0, 1, 0, 0);
        clr();
        txn(rnd64(), rnd64(), 2, 2, 0, 0, 1, 0, 0);
        txn(rnd64(), rnd64(), 2, 1, 1, 1, 0, 0, 0);
        clr();
        txn(rnd64(), rnd64(), TO + 1, 0, 0, 0, 0, 1, 0);
        txn(rnd64(), rnd64(), 2, 0, 0, 0, 0, 0, 0);
        txn(rnd64(), rnd64(), 1, 3, 0, 0, 0, 0, 1);
        txn(rnd64(), rnd64(), 1, 0, 0, 0, 0, 0, 0);
        force dut.op_count = 16'hFFFF;
        tick();
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        txn(rnd64(), rnd64(), 1, 0, 0, 0, 0, 0, 0);
        chk("op_count_wrap", op_count, 0);
        for (int n = 0; n < 60; n++) begin
            int lat, hold;
            bit rh;
            lat  = $urandom_range(1, TO + 1);
            rh   = $urandom_range(0, 9) == 0;
            hold = $urandom_range(0, 3);
            if (rh && hold < 2) hold = 2;
            txn(rnd64(), rnd64(), lat, hold, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rh);
            if ($urandom_range(0, 3) == 0) clr();
        end
        tick();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
